sum_normalizer: RTL and testbench
=================================

# sum_normalizer

Converts the signed two's-complement significand sum from the FP adder datapath back to sign-magnitude form and normalizes it. Shifts one bit per cycle and adjusts the exponent to match. Sits between the significand adder and the rounding stage, with valid/ready handshakes on both sides.

## Interface
- SIG_BITS, 23, stored fraction bits
- EXP_BITS, 8, exponent bits
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  sum/exponent valid
- in_ready  output  1  block can accept an input
- sum_in  input  SIG_BITS+6  signed sum [SIG_BITS+5:0]
  - bit SIG_BITS+5: sign
  - bit SIG_BITS+4: carry
  - bit SIG_BITS+3: hidden
  - bits 2/1/0: guard, round, sticky
- exp_in  input  EXP_BITS  biased exponent of the larger operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- sign_out  output  1  result sign
- mag_out  output  SIG_BITS+4  normalized magnitude: hidden, fraction, G, R, S
- exp_out  output  EXP_BITS  adjusted exponent
- zero  output  1  exact zero result
- overflow  output  1  exponent reached all-ones
- underflow  output  1  result is subnormal

## Operation
- States: IDLE, NORM, DONE (enum).
- IDLE: in_ready=1.
  - On in_valid, capture sign = sum_in[MSB].
  - Capture mag (SIG_BITS+5 bits) = sign ? low bits of (~sum_in+1) : low bits of sum_in.
  - Capture exp = exp_in, then go to NORM.
- NORM (one action per cycle, checked in this priority):
  - mag==0: zero=1, sign=0, exp=0, go to DONE.
  - exp==all-ones on entry: overflow=1, go to DONE.
  - Carry bit set: mag = mag>>1, with new bit0 = mag[1]|mag[0] (sticky preserved), exp+1.
    - If the new exp is all-ones: overflow=1, go to DONE.
    - Otherwise stay in NORM.
  - Hidden bit set: go to DONE.
  - Hidden bit clear and exp>1: mag = mag<<1 (zero fill), exp-1, stay in NORM.
  - Hidden bit clear and exp≤1: exp=0, underflow=1, go to DONE (subnormal encoding).
- DONE: out_valid=1, outputs held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in NORM and DONE.
- Exponent arithmetic is unsigned EXP_BITS; it never wraps, by the rules above.
- A negative sum and a carry cannot both occur (upstream guarantee). Correct behaviour is still required if they do.

## Timing
- Reset (asynchronous, any state): state=IDLE.
  - in_ready=1 after reset release.
  - out_valid, sign_out, mag_out, exp_out, zero, overflow, underflow all reset to 0.
  - A result in flight is discarded.
- Outputs are registered.
- Handshake: an input is accepted at the clk edge where in_valid & in_ready. The output transfers at the edge where out_valid & out_ready.
- Latency: with k = number of shift cycles, out_valid rises k+1 cycles after the accept edge.
  - Minimum 1 cycle (already normalized, or zero).
  - Worst case SIG_BITS+4 cycles (sticky-only sum).
- Back-to-back: next accept is possible on the cycle after the out_valid & out_ready edge (one IDLE cycle).
- out_ready held low: DONE is held indefinitely, outputs unchanged.

## Structure
- Shared package fp_pkg: SIG_BITS, EXP_BITS, state enum type, sum/mag width localparams.
- Sub-module abs_recover: combinational sign extraction and two's-complement negation of sum_in. The FSM and shifter stay in sum_normalizer.

## Test plan
- sum_in=0x0400_0000, exp_in=0x7F -> sign 0, mag 0x400_0000, exp 0x7F; out_valid 1 cycle after accept.
- sum_in=0x1C00_0000 (−0x400_0000), exp_in=0x7F -> sign 1, mag 0x400_0000, exp 0x7F.
- Carry: sum_in=0x0800_0003, exp_in=0x80 -> mag 0x400_0001 (sticky kept), exp 0x81. Same sum with exp_in=0xFE -> exp 0xFF, overflow 1.
- Cancellation: sum_in=0x0000_0008, exp_in=0x7F -> 23 left shifts, mag 0x400_0000, exp 0x68; out_valid 24 cycles after accept. sum_in=0 -> zero 1, mag 0, exp 0.
- Underflow: sum_in=0x0000_0100, exp_in=0x03 -> 2 shifts, mag 0x400, exp 0, underflow 1. Hold out_ready low 5 cycles: outputs stable, in_ready 0.
- Assert rst mid-NORM during the cancellation case -> all outputs 0 immediately. After release, a new input is accepted and processed correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths and normalizer state type for the FP adder datapath.
package fp_pkg;
    localparam int SIG_BITS = 23;
    localparam int EXP_BITS = 8;
    localparam int SUM_W    = SIG_BITS + 6;
    localparam int MAG_W    = SIG_BITS + 5;
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
endpackage

// File: rtl/abs_recover.sv
// abs_recover: splits a two's-complement sum into sign and magnitude (low bits only).
module abs_recover
    import fp_pkg::*;
#(
    parameter int SUM_W_P = SUM_W
) (
    input  logic [SUM_W_P-1:0] sum,
    output logic               neg,
    output logic [SUM_W_P-2:0] mag
);
    // low bits of the full negation equal the negation of the low bits
    assign neg = sum[SUM_W_P-1];
    assign mag = neg ? (~sum[SUM_W_P-2:0] + 1'b1) : sum[SUM_W_P-2:0];
endmodule

// File: rtl/sum_normalizer.sv
// sum_normalizer: converts the signed significand sum to sign-magnitude and
// normalizes it one bit per cycle, adjusting the exponent.
module sum_normalizer
    import fp_pkg::*;
#(
    parameter int SIG_BITS = fp_pkg::SIG_BITS,
    parameter int EXP_BITS = fp_pkg::EXP_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIG_BITS+5:0] sum_in,
    input  logic [EXP_BITS-1:0] exp_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sign_out,
    output logic [SIG_BITS+3:0] mag_out,
    output logic [EXP_BITS-1:0] exp_out,
    output logic                zero,
    output logic                overflow,
    output logic                underflow
);
    localparam int SW = SIG_BITS + 6;
    localparam int MW = SIG_BITS + 5;
    localparam logic [EXP_BITS-1:0] EXP_MAX = '1;
    localparam logic [EXP_BITS-1:0] EXP_ONE = EXP_BITS'(1);

    state_t state, state_n;
    logic [MW-1:0] mag_r, mag_n, abs_mag;
    logic [EXP_BITS-1:0] exp_r, exp_n;
    logic sign_r, sign_n, neg, fin, zero_n, ovf_n, unf_n;

    abs_recover #(.SUM_W_P(SW)) u_abs (
        .sum (sum_in),
        .neg (neg),
        .mag (abs_mag)
    );

    assign in_ready = (state == IDLE);

    always_comb begin
        state_n = state;
        sign_n  = sign_r;
        mag_n   = mag_r;
        exp_n   = exp_r;
        fin     = 1'b0;
        zero_n  = 1'b0;
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                sign_n  = neg;
                mag_n   = abs_mag;
                exp_n   = exp_in;
                state_n = NORM;
            end
            NORM: begin
                if (mag_r == '0) begin
                    sign_n = 1'b0;
                    exp_n  = '0;
                    zero_n = 1'b1;
                    fin    = 1'b1;
                end else if (exp_r == EXP_MAX) begin
                    ovf_n = 1'b1;
                    fin   = 1'b1;
                end else if (mag_r[MW-1]) begin
                    // right shift folds the dropped bit into sticky
                    mag_n = {1'b0, mag_r[MW-1:2], mag_r[1] | mag_r[0]};
                    exp_n = exp_r + 1'b1;
                    ovf_n = (exp_n == EXP_MAX);
                    fin   = ovf_n;
                end else if (mag_r[MW-2]) begin
                    fin = 1'b1;
                end else if (exp_r > EXP_ONE) begin
                    mag_n = mag_r << 1;
                    exp_n = exp_r - 1'b1;
                end else begin
                    exp_n = '0;
                    unf_n = 1'b1;
                    fin   = 1'b1;
                end
                state_n = fin ? DONE : NORM;
            end
            DONE: state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            mag_r     <= '0;
            exp_r     <= '0;
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            mag_out   <= '0;
            exp_out   <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_n;
            sign_r    <= sign_n;
            mag_r     <= mag_n;
            exp_r     <= exp_n;
            out_valid <= (state_n == DONE);
            if (fin) begin
                sign_out  <= sign_n;
                mag_out   <= mag_n[MW-2:0];
                exp_out   <= exp_n;
                zero      <= zero_n;
                overflow  <= ovf_n;
                underflow <= unf_n;
            end
        end
    end
endmodule

// File: tb/tb_sum_normalizer.sv
// tb_sum_normalizer: directed self-checking bench for sum_normalizer.
module tb_sum_normalizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [28:0] sum_in = '0;
    logic [7:0]  exp_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_out;
    logic [26:0] mag_out;
    logic [7:0]  exp_out;
    logic        zero, overflow, underflow;
    int total = 0;
    int bad = 0;
    int lat;

    sum_normalizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .mag_out(mag_out), .exp_out(exp_out),
        .zero(zero), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [28:0] s, input logic [7:0] e);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        sum_in   = s;
        exp_in   = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic res(input string tag, input int l, input logic sg, input logic [26:0] m,
                       input logic [7:0] e, input logic z, input logic o, input logic u);
        chk({tag, ".lat"}, 32'(lat), 32'(l));
        chk({tag, ".sign"}, 32'(sign_out), 32'(sg));
        chk({tag, ".mag"}, 32'(mag_out), 32'(m));
        chk({tag, ".exp"}, 32'(exp_out), 32'(e));
        chk({tag, ".flags"}, {29'd0, zero, overflow, underflow}, {29'd0, z, o, u});
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.outs", {out_valid, sign_out, mag_out, zero, overflow, underflow}, 32'd0);
        chk("rst.exp", 32'(exp_out), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        run("pos", 29'h0400_0000, 8'h7F);
        res("pos", 1, 1'b0, 27'h400_0000, 8'h7F, 1'b0, 1'b0, 1'b0);
        drain("pos");

        run("neg", 29'h1C00_0000, 8'h7F);
        res("neg", 1, 1'b1, 27'h400_0000, 8'h7F, 1'b0, 1'b0, 1'b0);
        drain("neg");

        run("carry", 29'h0800_0003, 8'h80);
        res("carry", 2, 1'b0, 27'h400_0001, 8'h81, 1'b0, 1'b0, 1'b0);
        drain("carry");

        run("carry_ovf", 29'h0800_0003, 8'hFE);
        res("carry_ovf", 1, 1'b0, 27'h400_0001, 8'hFF, 1'b0, 1'b1, 1'b0);
        drain("carry_ovf");

        run("entry_ovf", 29'h0400_0000, 8'hFF);
        res("entry_ovf", 1, 1'b0, 27'h400_0000, 8'hFF, 1'b0, 1'b1, 1'b0);
        drain("entry_ovf");

        run("cancel", 29'h0000_0008, 8'h7F);
        res("cancel", 24, 1'b0, 27'h400_0000, 8'h68, 1'b0, 1'b0, 1'b0);
        drain("cancel");

        run("zero", 29'h0000_0000, 8'h7F);
        res("zero", 1, 1'b0, 27'h0, 8'h00, 1'b1, 1'b0, 1'b0);
        drain("zero");

        run("negmax", 29'h1000_0000, 8'h40);
        res("negmax", 1, 1'b0, 27'h0, 8'h00, 1'b1, 1'b0, 1'b0);
        drain("negmax");

        run("sticky", 29'h0000_0001, 8'hC0);
        res("sticky", 27, 1'b0, 27'h400_0000, 8'hA6, 1'b0, 1'b0, 1'b0);
        drain("sticky");

        run("unf", 29'h0000_0100, 8'h03);
        res("unf", 3, 1'b0, 27'h400, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold.valid", 32'(out_valid), 32'd1);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            chk("hold.mag", 32'(mag_out), 32'h400);
            chk("hold.flags", {29'd0, zero, overflow, underflow}, 32'd1);
        end
        drain("unf");

        run("midrst", 29'h0000_0008, 8'h7F);
        chk("midrst.timeout_guard", 32'(lat), 32'd24);
        drain("midrst");
        sum_in   = 29'h0000_0008;
        exp_in   = 8'h7F;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst.outs", {out_valid, sign_out, mag_out, zero, overflow, underflow}, 32'd0);
        chk("midrst.exp", 32'(exp_out), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run("after_rst", 29'h1C00_0000, 8'h7F);
        res("after_rst", 1, 1'b1, 27'h400_0000, 8'h7F, 1'b0, 1'b0, 1'b0);
        drain("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
